// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame scheduler: FSM state encoding, frame
// field positions and the saturating bit counter helper.
package spi_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_HDR     = 6'b000010,
    ST_RD_REQ  = 6'b000100,
    ST_RD_DATA = 6'b001000,
    ST_WR_DATA = 6'b010000,
    ST_WR_REQ  = 6'b100000
  } state_e;

  localparam int RW_BIT     = 63;
  localparam int ADDR_MSB   = 47;
  localparam int ADDR_LSB   = 32;
  localparam int DATA_MSB   = 31;
  localparam int HDR_BITS   = 32;
  localparam int FRAME_BITS = 64;

  localparam int               CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

  // Saturates one past a full frame so that any extra bit marks the frame long.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_SAT) ? CNT_SAT : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// One-cycle delay flop on a synchronised input with combinational rise/fall
// strobes, valid in the first clk where the input differs from its delayed copy.
module spi_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_s,
  output logic rise,
  output logic fall
);

  logic sig_d;
  logic sig_q;

  always_comb sig_d = sig_s;

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge, so every flop here and below is a plain DFF.
  always_ff @(posedge clk) begin
    if (rst) sig_q <= RST_VAL;
    else     sig_q <= sig_d;
  end

  assign rise = sig_s & ~sig_q;
  assign fall = ~sig_s & sig_q;

endmodule

// File: rtl/spi_frame_sched.sv
// SPI slave frame scheduler: shifts in a 64-bit mode-3 frame, runs one
// register-bus read or write, and returns read data on MISO in the same frame.
module spi_frame_sched
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_s,
  input  logic              spi_sck_s,
  input  logic              spi_mosi_s,
  output logic              spi_miso,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic cs_rise, cs_fall, sck_rise, sck_fall;

  spi_edge_det #(.RST_VAL(1'b1)) u_cs_det (
    .clk   (clk),
    .rst   (rst),
    .sig_s (spi_cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_edge_det #(.RST_VAL(1'b1)) u_sck_det (
    .clk   (clk),
    .rst   (rst),
    .sig_s (spi_sck_s),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  rx_q,      rx_d;
  logic [DATA_W-1:0]  tx_q,      tx_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [DATA_W-1:0]  wdata_q,   wdata_d;
  logic [TMO_W-1:0]   tmo_q,     tmo_d;
  logic               req_q,     req_d;
  logic               wr_q,      wr_d;
  logic               miso_q,    miso_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;
  logic               busy_q,    busy_d;
  logic               fail_q,    fail_d;
  logic               cs_up_q,   cs_up_d;

  logic              sample, shift_out, ack, tmo_hit, shifting;
  logic [DATA_W-1:0] rx_shift;

  assign sample    = sck_rise & ~spi_cs_s;
  assign shift_out = sck_fall & ~spi_cs_s;
  assign ack       = reg_ack & req_q;
  assign tmo_hit   = req_q & ~reg_ack & (tmo_q == TMO_W'(TIMEOUT - 1));
  assign rx_shift  = {rx_q[DATA_W-2:0], spi_mosi_s};
  assign shifting  = (state_q == ST_HDR) || (state_q == ST_WR_DATA) ||
                     (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    wr_d      = wr_q;
    miso_d    = miso_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail_d    = fail_q;
    cs_up_d   = cs_up_q;

    if (req_q) tmo_d = tmo_q + TMO_W'(1);

    if (shifting && sample) begin
      rx_d      = rx_shift;
      bit_cnt_d = cnt_inc(bit_cnt_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = ST_HDR;
          bit_cnt_d = '0;
          rx_d      = '0;
          fail_d    = 1'b0;
          cs_up_d   = 1'b0;
        end
      end

      ST_HDR: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sample && bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
          addr_d = rx_shift[ADDR_LSB-HDR_BITS +: ADDR_W];
          tmo_d  = '0;
          tx_d   = '0;
          if (rx_shift[RW_BIT-HDR_BITS]) begin
            state_d = ST_RD_REQ;
            req_d   = 1'b1;
            wr_d    = 1'b0;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
      end

      ST_RD_REQ: begin
        // A data-phase clock edge before the ack means the first MISO bit is
        // already gone; the frame is doomed but the bus handshake completes.
        if (shift_out) begin
          miso_d = 1'b0;
          fail_d = 1'b1;
        end
        if (cs_rise) cs_up_d = 1'b1;
        if (ack) begin
          req_d = 1'b0;
          if (cs_up_q || cs_rise) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_DATA;
            tx_d    = (fail_q || shift_out) ? '0 : reg_rdata;
          end
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RD_DATA: begin
        if (shift_out) begin
          miso_d = tx_q[DATA_MSB];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
          if (bit_cnt_q == CNT_W'(FRAME_BITS) && !fail_q) done_d = 1'b1;
          else                                             err_d  = 1'b1;
        end
      end

      ST_WR_DATA: begin
        if (cs_rise) begin
          if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
            state_d = ST_WR_REQ;
            req_d   = 1'b1;
            wr_d    = 1'b1;
            wdata_d = rx_q;
            tmo_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WR_REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        miso_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      miso_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
      cs_up_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      miso_q    <= miso_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      fail_q    <= fail_d;
      cs_up_q   <= cs_up_d;
    end
  end

  assign spi_miso   = miso_q;
  assign reg_req    = req_q;
  assign reg_wr     = wr_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: doc/spi_frame_sched.md
Name: spi_frame_sched

Overview:
- Sequences one SPI slave transaction end to end: shifts in a 64-bit MOSI frame, decodes the R/W bit, runs one register-bus access, and shifts read data out on MISO within the same frame.
- Sits between the SPI input synchroniser stage and the register bank. It owns the only register-bus master port on the SPI side.

Parameters:
- ADDR_W, 16, register address width; frame bits [47:32], upper unused bits ignored.
- DATA_W, 32, register data width; frame bits [31:0], fixed at 32.
- TIMEOUT, 64, clk cycles to wait for reg_ack before the access is aborted.

Ports:
- clk  in  1  system clock; SPI inputs are oversampled at ≥8× sck.
- rst  in  1  synchronous, active-high reset.
- spi_cs_s  in  1  synchronised chip select, active low.
- spi_sck_s  in  1  synchronised SPI clock, mode 3 (idles high).
- spi_mosi_s  in  1  synchronised MOSI.
- spi_miso  out  1  MISO data.
- reg_req  out  1  bus request; held high until reg_ack or timeout.
- reg_wr  out  1  1 = write, 0 = read; valid while reg_req is high.
- reg_addr  out  ADDR_W  access address.
- reg_wdata  out  32  write data.
- reg_ack  in  1  single-cycle completion; reg_rdata is valid in the same cycle.
- reg_rdata  in  32  read data.
- frame_done  out  1  one-cycle pulse when a frame completes cleanly.
- frame_err  out  1  one-cycle pulse on a short frame, long frame, timeout or abort.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, bit_cnt is 0, shift registers are 0. The internal edge-detect flops reset to cs=1, sck=1.
- Edge detection: one internal delay flop per input.
  - sck_rise = sck_s & ~sck_d; sck_fall = ~sck_s & sck_d.
  - cs_fall and cs_rise are defined the same way.
  - Events are seen one clk after the synchronised input changes.
- Frame format, MSB first, sampled on sck_rise while cs is low:
  - [63] rw (0 = write, 1 = read); [62:48] reserved; [47:32] addr; [31:0] wdata (don't-care for reads).
- bit_cnt: 7 bits, counts sampled bits 0..64. The counter saturates at 65, which marks the frame as long.
- States:
  - IDLE: on cs_fall, clear bit_cnt and go to HDR.
  - HDR: shift MOSI in. When bit_cnt reaches 32, latch rw and addr.
    - rw = 1: go to RD_REQ.
    - rw = 0: go to WR_DATA.
  - RD_REQ: raise reg_req with reg_wr=0. On reg_ack, load reg_rdata into the tx shifter and go to RD_DATA.
    - The ack must arrive before the first sck_fall after bit 32.
    - If that sck_fall comes first, the tx shifter is loaded with 0, the error is latched, and reg_req stays high until ack or timeout.
  - RD_DATA: on each sck_fall, drive spi_miso with tx[31] and shift left; MISO bits are counted alongside MOSI.
    - cs_rise with bit_cnt = 64 and no latched error: frame_done, go to IDLE.
    - Any other cs_rise: frame_err, go to IDLE.
  - WR_DATA: keep shifting. On cs_rise:
    - bit_cnt = 64: go to WR_REQ.
    - Otherwise: frame_err, go to IDLE, no bus access.
  - WR_REQ: reg_req=1, reg_wr=1, addr and wdata held stable.
    - reg_ack: frame_done, go to IDLE.
    - Timeout: frame_err, go to IDLE.
- Timeout counter:
  - Cleared on entry to RD_REQ or WR_REQ.
  - When it reaches TIMEOUT-1 without an ack, reg_req drops next cycle and frame_err pulses.
- spi_miso is 0 outside RD_DATA and during the bit preceding the first data bit.
- cs_rise in HDR (fewer than 32 bits): frame_err, go to IDLE.
- cs_rise in RD_REQ: reg_req stays high until ack or timeout (a handshake is never dropped mid-access), then frame_err and IDLE.
- cs_fall while not IDLE: ignored. That frame is lost and the host must re-send.
- reg_ack while reg_req is low: ignored.
- Reset mid-access drops reg_req in the next cycle; the register bank tolerates this.

Decomposition:
- Shared package spi_pkg holds:
  - state encodings (one-hot, 6 states);
  - frame field positions: RW_BIT=63, ADDR_MSB=47, ADDR_LSB=32, DATA_MSB=31;
  - HDR_BITS=32 and FRAME_BITS=64.
- One sub-module, spi_edge_det: a per-signal delay flop with rise/fall outputs, instantiated for cs and sck.

Test Plan:
- Write frame: mosi=0x0000_0012_CAFE_F00D, 64 bits, ack after 3 cycles → one reg_req with reg_wr=1, reg_addr=0x0012, reg_wdata=0xCAFEF00D; frame_done pulses once; frame_err stays 0.
- Read frame: header 0x8000_0034, reg_rdata=0xA5A5_1234 acked after 2 cycles → reg_addr=0x0034, reg_wr=0; MISO bits 32..63 as sampled by the host equal 0xA5A51234; frame_done pulses.
- Short write: cs rises after 40 bits → no reg_req ever; frame_err pulses once; busy falls the next cycle.
- Timeout: write frame with reg_ack held 0 → reg_req high for exactly 64 cycles then low; frame_err pulses; next frame is accepted normally.
- Late read ack: ack arrives after the first sck_fall of the data phase → MISO data = 0x00000000; frame_err at cs_rise; no frame_done.
- Reset asserted in WR_REQ → next cycle reg_req=0, busy=0, no pulses; a following write frame completes correctly.
